narnet_seq_ctrl: RTL
====================

Name: narnet_seq_ctrl

Overview:
Sequencer that drives one NARNet inference core (the 16-tap, 5-hidden-neuron fixed-point predictor) over a stream of samples.
- Buffers measured samples in a small FIFO.
- Issues each sample to the core with the core's x_ready/out_ready pulse handshake.
- On command, runs closed-loop multi-step prediction, feeding each core output back as the next input for H steps.
- Includes a watchdog that resets a hung core.

Parameters:
N, 10, sample/prediction word width (signed fixed point)
Q, 8, fractional bits (pass-through only; no arithmetic on Q)
FIFO_DEPTH, 8, input sample FIFO depth (power of two, >=2)
HZN_W, 6, width of horizon command
TIMEOUT, 512, max cycles from issue to core out_ready before watchdog fires

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  global run; when 0 the FSM, FIFO pops and watchdog freeze (pushes still accepted)
s_valid  in  1  measured sample valid
s_data  in  N  measured sample, signed
s_ready  out  1  FIFO not full
cmd_start  in  1  one-cycle request for closed-loop run
cmd_horizon  in  HZN_W  closed-loop step count H
core_enable  out  1  drives core enable (= enable)
core_rst  out  1  drives core rst
core_x_in  out  N  sample to core
core_x_ready  out  1  one-cycle issue strobe to core
core_y_out  in  N  core prediction
core_out_ready  in  1  core one-cycle done strobe
p_valid  out  1  one-cycle prediction strobe
p_data  out  N  prediction
p_closed  out  1  1 = closed-loop step, 0 = one-step-ahead on a measured sample
p_last  out  1  final step of a closed-loop run
busy  out  1  state != IDLE or a command is pending
err_cmd  out  1  one-cycle pulse: command rejected
err_timeout  out  1  one-cycle pulse: watchdog fired

Behaviour:
- Reset values:
  - All outputs 0 except core_rst = 1 during rst.
  - FIFO empty; state IDLE; have_pred = 0; pending = 0; wd counter = 0.
- core_rst = rst OR wd_rst, where wd_rst is a registered one-cycle pulse.
- FIFO:
  - Push when s_valid && s_ready.
  - s_ready = (count != FIFO_DEPTH), registered from count.
  - Pop happens only in the IDLE->ISSUE transition.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Command:
  - cmd_start with H != 0 and have_pred = 1 and pending = 0 and not in closed loop: latch H, set pending.
  - Otherwise (H = 0, no prediction yet, pending already set, or a closed-loop run active): pulse err_cmd the next cycle and drop the command.
- States:
  - IDLE (when enable = 1):
    - If pending: core_x_in <= last_pred; steps <= H; pending <= 0; mode = closed; go ISSUE.
    - Else if FIFO non-empty: pop to core_x_in; mode = open; go ISSUE.
    - Pending has priority over FIFO.
  - ISSUE: core_x_ready = 1 for exactly this one cycle; clear wd counter; go WAIT.
  - WAIT:
    - Count cycles.
    - On core_out_ready = 1:
      - Register core_y_out into last_pred and p_data; set have_pred.
      - Next cycle: p_valid = 1, p_closed = mode; p_last = 1 if mode = closed and steps = 1.
      - Go NEXT.
    - If the counter reaches TIMEOUT-1 first:
      - Pulse wd_rst and err_timeout.
      - Abort the closed run (steps = 0, pending = 0); go IDLE.
      - have_pred is cleared, since core history is lost.
  - NEXT:
    - If mode = closed and steps > 1: steps--, core_x_in <= last_pred, go ISSUE.
    - Otherwise go IDLE.
    - The core re-enters its wait state the cycle after out_ready, so re-issuing from NEXT is legal.
- Latency:
  - Sample pushed into an empty FIFO in cycle t while IDLE: core_x_ready at t+2.
  - p_valid asserts 1 cycle after core_out_ready.
- During a closed-loop run, measured samples keep queueing. FIFO full only deasserts s_ready; nothing is dropped.
- enable = 0:
  - The state holds and the wd counter holds.
  - core_out_ready arriving while frozen is not lost: captured in a sticky flag and consumed when enable returns.
- rst mid-operation: immediate return to reset values next cycle; the in-flight core result is discarded.

Test Plan:
- Reset, push samples 0x061, 0x080, 0x0A0 (core model returns x+1 after 40 cycles) -> three issues in order; p_valid with p_data 0x062, 0x081, 0x0A1; p_closed = 0; s_ready stays 1.
- After one prediction 0x062, cmd_start H = 3 -> core_x_in sequence 0x062, 0x063, 0x064; p_data 0x063, 0x064, 0x065 with p_closed = 1; p_last only on 0x065.
- Push 10 samples while core busy (FIFO_DEPTH 8) -> s_ready low after 8 accepted; s_valid held until it rises; all 10 processed in order, none lost.
- cmd_start right after reset (have_pred = 0), then H = 0, then a second cmd_start during a closed run -> err_cmd pulse each time; no closed-loop issue.
- Core model never asserts out_ready -> err_timeout and core_rst pulse exactly TIMEOUT cycles after issue; FSM returns to IDLE; next FIFO sample issues normally.
- Assert rst mid closed-loop run and toggle enable = 0 across an out_ready pulse -> outputs return to reset values after rst; the frozen out_ready is delivered as p_valid once enable returns.

Source files
------------

// File: rtl/narnet_seq_ctrl.sv
// narnet_seq_ctrl: queues measured samples, hands them one at a time to a
// NARNet inference core with the x_ready/out_ready pulse handshake, runs
// closed-loop multi-step prediction on command and resets a hung core.
//
// state  | meaning
// IDLE   | waiting for a pending closed-loop command or a queued sample
// ISSUE  | one-cycle core_x_ready strobe, watchdog armed
// WAIT   | waiting for core_out_ready, watchdog counting down
// NEXT   | prediction strobe out; re-issue for the next closed-loop step or finish
module narnet_seq_ctrl #(
  parameter int N          = 10,
  parameter int Q          = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int HZN_W      = 6,
  parameter int TIMEOUT    = 512
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             s_valid_i,
  input  logic [N-1:0]     s_data_i,
  output logic             s_ready_o,
  input  logic             cmd_start_i,
  input  logic [HZN_W-1:0] cmd_horizon_i,
  output logic             core_enable_o,
  output logic             core_rst_o,
  output logic [N-1:0]     core_x_in_o,
  output logic             core_x_ready_o,
  input  logic [N-1:0]     core_y_out_i,
  input  logic             core_out_ready_i,
  output logic             p_valid_o,
  output logic [N-1:0]     p_data_o,
  output logic             p_closed_o,
  output logic             p_last_o,
  output logic             busy_o,
  output logic             err_cmd_o,
  output logic             err_timeout_o
);

  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  // Watchdog is a down-counter: loaded at ISSUE so that its terminal count
  // lands the wd_rst pulse exactly TIMEOUT cycles after the issue strobe.
  localparam logic [WW-1:0] WD_LOAD  = WW'(TIMEOUT - 2);

  // Q only describes the fixed-point format of the words passed through.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 2 || Q >= N)
  begin : g_bad_params
    $error("narnet_seq_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_NEXT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             s_ready_q, s_ready_d;
  logic [N-1:0]     x_in_q, x_in_d;
  logic             mode_q, mode_d;
  logic [HZN_W-1:0] steps_q, steps_d;
  logic [HZN_W-1:0] hzn_q, hzn_d;
  logic             pending_q, pending_d;
  logic             have_pred_q, have_pred_d;
  logic [N-1:0]     last_pred_q, last_pred_d;
  logic [N-1:0]     p_data_q, p_data_d;
  logic             p_valid_q, p_valid_d;
  logic             p_closed_q, p_closed_d;
  logic             p_last_q, p_last_d;
  logic             err_cmd_q, err_cmd_d;
  logic             err_to_q, err_to_d;
  logic             wd_rst_q, wd_rst_d;
  logic [WW-1:0]    wd_cnt_q, wd_cnt_d;
  logic             sticky_q, sticky_d;
  logic [N-1:0]     hold_q, hold_d;

  logic             push, pop, pend_take, consume, wd_fire, cmd_ok, closed_active;
  logic [N-1:0]     y_sel;

  assign push          = s_valid_i & s_ready_q;
  assign closed_active = mode_q & (state_q != S_IDLE);
  assign cmd_ok        = cmd_start_i & (cmd_horizon_i != '0) & have_pred_q &
                         ~pending_q & ~closed_active;

  // Sequencer next state: issue ordering, handshake capture and watchdog.
  always_comb begin
    state_d   = state_q;
    x_in_d    = x_in_q;
    mode_d    = mode_q;
    steps_d   = steps_q;
    wd_cnt_d  = wd_cnt_q;
    sticky_d  = sticky_q;
    hold_d    = hold_q;
    pop       = 1'b0;
    pend_take = 1'b0;
    consume   = 1'b0;
    wd_fire   = 1'b0;
    y_sel     = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          if (pending_q) begin
            x_in_d    = last_pred_q;
            steps_d   = hzn_q;
            pend_take = 1'b1;
            mode_d    = 1'b1;
            state_d   = S_ISSUE;
          end else if (count_q != '0) begin
            pop     = 1'b1;
            x_in_d  = mem_q[rd_ptr_q];
            mode_d  = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (enable_i) begin
          wd_cnt_d = WD_LOAD;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable_i) begin
          // A result arriving while frozen is parked until enable returns.
          if (core_out_ready_i) begin
            sticky_d = 1'b1;
            hold_d   = core_y_out_i;
          end
        end else if (core_out_ready_i || sticky_q) begin
          consume  = 1'b1;
          sticky_d = 1'b0;
          y_sel    = core_out_ready_i ? core_y_out_i : hold_q;
          state_d  = S_NEXT;
        end else if (wd_cnt_q == '0) begin
          wd_fire = 1'b1;
          steps_d = '0;
          state_d = S_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q - WW'(1);
        end
      end
      S_NEXT: begin
        if (enable_i) begin
          if (mode_q && (steps_q > HZN_W'(1))) begin
            steps_d = steps_q - HZN_W'(1);
            x_in_d  = last_pred_q;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping, command acceptance and result/strobe generation.
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    s_ready_d = (count_d != FULL_CNT);

    hzn_d     = cmd_ok ? cmd_horizon_i : hzn_q;
    err_cmd_d = cmd_start_i & ~cmd_ok;
    pending_d = pending_q;
    if (wd_fire) begin
      pending_d = 1'b0;
    end else if (cmd_ok) begin
      pending_d = 1'b1;
    end else if (pend_take) begin
      pending_d = 1'b0;
    end

    have_pred_d = have_pred_q;
    if (wd_fire) begin
      have_pred_d = 1'b0;
    end else if (consume) begin
      have_pred_d = 1'b1;
    end
    last_pred_d = consume ? y_sel : last_pred_q;
    p_data_d    = consume ? y_sel : p_data_q;
    p_valid_d   = consume;
    p_closed_d  = consume & mode_q;
    p_last_d    = consume & mode_q & (steps_q == HZN_W'(1));
    err_to_d    = wd_fire;
    wd_rst_d    = wd_fire;
  end

  // Control and datapath registers, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      s_ready_q   <= 1'b0;
      x_in_q      <= '0;
      mode_q      <= 1'b0;
      steps_q     <= '0;
      hzn_q       <= '0;
      pending_q   <= 1'b0;
      have_pred_q <= 1'b0;
      last_pred_q <= '0;
      p_data_q    <= '0;
      p_valid_q   <= 1'b0;
      p_closed_q  <= 1'b0;
      p_last_q    <= 1'b0;
      err_cmd_q   <= 1'b0;
      err_to_q    <= 1'b0;
      wd_rst_q    <= 1'b0;
      wd_cnt_q    <= '0;
      sticky_q    <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      s_ready_q   <= s_ready_d;
      x_in_q      <= x_in_d;
      mode_q      <= mode_d;
      steps_q     <= steps_d;
      hzn_q       <= hzn_d;
      pending_q   <= pending_d;
      have_pred_q <= have_pred_d;
      last_pred_q <= last_pred_d;
      p_data_q    <= p_data_d;
      p_valid_q   <= p_valid_d;
      p_closed_q  <= p_closed_d;
      p_last_q    <= p_last_d;
      err_cmd_q   <= err_cmd_d;
      err_to_q    <= err_to_d;
      wd_rst_q    <= wd_rst_d;
      wd_cnt_q    <= wd_cnt_d;
      sticky_q    <= sticky_d;
      hold_q      <= hold_d;
    end
  end

  // Sample storage; no reset needed since count gates every read.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= s_data_i;
    end
  end

  assign s_ready_o      = s_ready_q;
  assign core_enable_o  = enable_i & ~rst_i;
  assign core_rst_o     = rst_i | wd_rst_q;
  assign core_x_in_o    = x_in_q;
  assign core_x_ready_o = (state_q == S_ISSUE) & enable_i;
  assign p_valid_o      = p_valid_q;
  assign p_data_o       = p_data_q;
  assign p_closed_o     = p_closed_q;
  assign p_last_o       = p_last_q;
  assign busy_o         = (state_q != S_IDLE) | pending_q;
  assign err_cmd_o      = err_cmd_q;
  assign err_timeout_o  = err_to_q;

endmodule
